// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ARM-style ALU: opcodes, flag indices,
// control FSM states and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // TST/TEQ/CMP/CMN: always update flags, never write a result
  function automatic logic is_compare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // AND EOR TST TEQ ORR MOV BIC MVN take C from the shifter and keep V
  function automatic logic is_logic(input logic [3:0] op);
    return (op[3:1] == 3'b000) || (op[3:1] == 3'b100) || (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// accumulator preloaded with the MLA addend.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] acc_init,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The completing edge is the one that takes cnt to WIDTH, so the final
  // partial-product step is forwarded straight to the result port.
  assign done    = run && (cnt_q == CNT_W'(WIDTH - 1));
  assign result  = acc_sum;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = acc_init;
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      cnt_d    = '0;
    end else if (run) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered data-processing ALU with NZCV flag register, valid/ready
// handshakes and an optional iterative MUL/MLA unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             op_mul,
  input  logic             mul_acc,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  input  logic             sh_c,
  input  logic             flags_ld,
  input  logic [3:0]       flags_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             res_we,
  output logic [3:0]       nzcv,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             res_we_q, res_we_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic             mul_s_q, mul_s_d;

  logic             accept, mul_go, alu_go, mul_run, mul_done;
  logic [WIDTH-1:0] mul_init, mul_res;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_go   = accept && op_mul && (MUL_EN != 0);
  assign alu_go   = accept && !mul_go;
  assign mul_run  = (state_q == MUL);
  assign mul_init = mul_acc ? src_c : '0;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_go),
        .run       (mul_run),
        .acc_init  (mul_init),
        .mcand_in  (src_a),
        .mplier_in (src_b),
        .done      (mul_done),
        .result    (mul_res)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_res  = '0;
    end
  endgenerate

  // Single shared adder: every arithmetic op reduces to x + y + cin, which
  // keeps C (bit WIDTH) and V consistent across add and subtract forms.
  logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             f_n, f_z, f_c, f_v;

  always_comb begin
    add_x     = src_a;
    add_y     = src_b;
    add_cin   = 1'b0;
    logic_res = '0;
    case (alu_op)
      OP_AND, OP_TST: logic_res = src_a & src_b;
      OP_EOR, OP_TEQ: logic_res = src_a ^ src_b;
      OP_ORR:         logic_res = src_a | src_b;
      OP_MOV:         logic_res = src_b;
      OP_BIC:         logic_res = src_a & ~src_b;
      OP_MVN:         logic_res = ~src_b;
      OP_SUB, OP_CMP: begin add_y = ~src_b; add_cin = 1'b1; end
      OP_RSB:         begin add_x = src_b; add_y = ~src_a; add_cin = 1'b1; end
      OP_ADC:         add_cin = nzcv_q[FLG_C];
      OP_SBC:         begin add_y = ~src_b; add_cin = nzcv_q[FLG_C]; end
      OP_RSC:         begin add_x = src_b; add_y = ~src_a; add_cin = nzcv_q[FLG_C]; end
      default:        ;
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + (WIDTH + 1)'(add_cin);
  assign alu_res = is_logic(alu_op) ? logic_res : sum[WIDTH-1:0];
  assign f_n     = alu_res[WIDTH-1];
  assign f_z     = (alu_res == '0);
  assign f_c     = is_logic(alu_op) ? sh_c : sum[WIDTH];
  assign f_v     = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    res_we_d    = res_we_q;
    nzcv_d      = nzcv_q;
    mul_s_d     = mul_s_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      alu_out_d   = '0;
      res_we_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mul_go) begin
          state_d = MUL;
          mul_s_d = set_flags;
        end else if (alu_go) begin
          out_valid_d = 1'b1;
          alu_out_d   = alu_res;
          res_we_d    = !is_compare(alu_op);
          if (set_flags || is_compare(alu_op)) begin
            nzcv_d[FLG_N] = f_n;
            nzcv_d[FLG_Z] = f_z;
            nzcv_d[FLG_C] = f_c;
            if (!is_logic(alu_op)) nzcv_d[FLG_V] = f_v;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = mul_res;
          res_we_d    = 1'b1;
          if (mul_s_q) begin
            nzcv_d[FLG_N] = mul_res[WIDTH-1];
            nzcv_d[FLG_Z] = (mul_res == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A direct MSR-style load overrides any op-driven update on the same edge
    if (flags_ld) nzcv_d = flags_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      res_we_q    <= 1'b0;
      nzcv_q      <= 4'b0000;
      mul_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      res_we_q    <= res_we_d;
      nzcv_q      <= nzcv_d;
      mul_s_q     <= mul_s_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign res_we    = res_we_q;
  assign nzcv      = nzcv_q;
  assign busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: hand-derived vector table, multi-cycle
// corner sequences and randomized ops against a plain-arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_mul, mul_acc, set_flags, sh_c;
  logic        flags_ld, out_valid, out_ready, res_we, busy;
  logic [3:0]  alu_op, flags_d, nzcv;
  logic [31:0] src_a, src_b, src_c, alu_out;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_nzcv;

  alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_mul(op_mul), .mul_acc(mul_acc), .set_flags(set_flags),
    .src_a(src_a), .src_b(src_b), .src_c(src_c), .sh_c(sh_c),
    .flags_ld(flags_ld), .flags_d(flags_d), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .res_we(res_we), .nzcv(nzcv),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true unsigned/signed results of the ARM operation.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                  input logic s, shc, input logic [3:0] f,
                                  output logic [31:0] r, output logic we,
                                  output logic [3:0] nf);
    longint ua, ub, sa, sb, full, sfull, c1, lim;
    logic arith, sub;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c1 = f[1] ? 1 : 0;
    lim = 64'sd2147483648;
    arith = 1'b1; sub = 1'b0; r = '0; full = 0; sfull = 0;
    case (op)
      OP_AND, OP_TST: begin r = a & b;  arith = 1'b0; end
      OP_EOR, OP_TEQ: begin r = a ^ b;  arith = 1'b0; end
      OP_ORR:         begin r = a | b;  arith = 1'b0; end
      OP_MOV:         begin r = b;      arith = 1'b0; end
      OP_BIC:         begin r = a & ~b; arith = 1'b0; end
      OP_MVN:         begin r = ~b;     arith = 1'b0; end
      OP_ADD, OP_CMN: begin full = ua + ub; sfull = sa + sb; end
      OP_ADC:         begin full = ua + ub + c1; sfull = sa + sb + c1; end
      OP_SUB, OP_CMP: begin sub = 1'b1; full = ua - ub; sfull = sa - sb; end
      OP_SBC:         begin sub = 1'b1; full = ua - ub - (1 - c1); sfull = sa - sb - (1 - c1); end
      OP_RSB:         begin sub = 1'b1; full = ub - ua; sfull = sb - sa; end
      default:        begin sub = 1'b1; full = ub - ua - (1 - c1); sfull = sb - sa - (1 - c1); end
    endcase
    if (arith) r = full[31:0];
    we = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
    nf = f;
    if (s || !we) begin
      nf[3] = r[31];
      nf[2] = (r == 32'd0);
      nf[1] = arith ? (sub ? (full >= 0) : (full > longint'(32'hFFFF_FFFF))) : shc;
      if (arith) nf[0] = (sfull >= lim) || (sfull < -lim);
    end
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, c,
                       input logic mul, acc, s, shc, ld, input logic [3:0] fd);
    chk("in_ready before accept", in_ready, 1);
    alu_op = op; src_a = a; src_b = b; src_c = c; op_mul = mul; mul_acc = acc;
    set_flags = s; sh_c = shc; flags_ld = ld; flags_d = fd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_mul = 1'b0; mul_acc = 1'b0; set_flags = 1'b0; flags_ld = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flags_ld = 1'b1; flags_d = f;
    @(posedge clk); #1;
    flags_ld = 1'b0;
    m_nzcv = f;
  endtask

  task automatic run_alu(input logic [3:0] op, input logic [31:0] a, b,
                         input logic s, shc, ld, input logic [3:0] fd);
    logic [31:0] r; logic we; logic [3:0] nf;
    ref_alu(op, a, b, s, shc, m_nzcv, r, we, nf);
    if (ld) nf = fd;
    drive(op, a, b, 32'd0, 1'b0, 1'b0, s, shc, ld, fd);
    chk($sformatf("op%0h out_valid", op), out_valid, 1);
    chk($sformatf("op%0h res_we", op), res_we, we);
    if (we) chk($sformatf("op%0h a=%h b=%h alu_out", op, a, b), alu_out, r);
    chk($sformatf("op%0h a=%h b=%h nzcv", op, a, b), nzcv, nf);
    m_nzcv = nf;
  endtask

  task automatic run_mul(input logic [31:0] a, b, c, input logic acc, s, ld,
                         input logic [3:0] fd);
    logic [63:0] prod; logic [31:0] r; int lat; logic stall_ok;
    prod = 64'(a) * 64'(b);
    r = prod[31:0] + (acc ? c : 32'd0);
    if (ld) m_nzcv = fd;
    if (s) begin m_nzcv[3] = r[31]; m_nzcv[2] = (r == 32'd0); end
    drive(4'h0, a, b, c, 1'b1, acc, s, 1'b0, ld, fd);
    lat = 0; stall_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("mul latency", lat, 32);
    chk("mul busy/in_ready while multiplying", stall_ok, 1);
    chk($sformatf("mul %h*%h+%h alu_out", a, b, acc ? c : 32'd0), alu_out, r);
    chk("mul res_we", res_we, 1);
    chk("mul nzcv", nzcv, m_nzcv);
    chk("mul busy after done", busy, 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    logic [3:0]  pre;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        s, shc;
    logic [31:0] out;
    logic        we;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{4'b0000, OP_ADD, 32'h7FFF_FFFF, 32'h1,         1'b1, 1'b0, 32'h8000_0000, 1'b1, 4'b1001};
    tbl[1]  = '{4'b0000, OP_CMP, 32'd5,         32'd5,         1'b0, 1'b0, 32'h0,         1'b0, 4'b0110};
    tbl[2]  = '{4'b0000, OP_SUB, 32'd7,         32'd0,         1'b1, 1'b0, 32'd7,         1'b1, 4'b0010};
    tbl[3]  = '{4'b0010, OP_SBC, 32'd7,         32'd3,         1'b0, 1'b0, 32'd4,         1'b1, 4'b0010};
    tbl[4]  = '{4'b0000, OP_SBC, 32'd7,         32'd3,         1'b0, 1'b0, 32'd3,         1'b1, 4'b0000};
    tbl[5]  = '{4'b0011, OP_ADC, 32'd0,         32'd0,         1'b0, 1'b0, 32'd1,         1'b1, 4'b0011};
    tbl[6]  = '{4'b0000, OP_RSB, 32'd3,         32'd10,        1'b1, 1'b0, 32'd7,         1'b1, 4'b0010};
    tbl[7]  = '{4'b0000, OP_RSC, 32'd3,         32'd10,        1'b1, 1'b0, 32'd6,         1'b1, 4'b0010};
    tbl[8]  = '{4'b0000, OP_SUB, 32'd0,         32'd1,         1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 4'b1000};
    tbl[9]  = '{4'b0001, OP_AND, 32'hF0F0,      32'h0FF0,      1'b1, 1'b1, 32'h00F0,      1'b1, 4'b0011};
    tbl[10] = '{4'b1111, OP_EOR, 32'hFF,        32'hFF,        1'b1, 1'b0, 32'h0,         1'b1, 4'b0101};
    tbl[11] = '{4'b0000, OP_TST, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'b1010};
    tbl[12] = '{4'b0001, OP_TEQ, 32'd5,         32'd5,         1'b0, 1'b0, 32'h0,         1'b0, 4'b0101};
    tbl[13] = '{4'b0000, OP_CMN, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b0, 4'b0110};
    tbl[14] = '{4'b1001, OP_ORR, 32'h0F00,      32'h00F0,      1'b0, 1'b1, 32'h0FF0,      1'b1, 4'b1001};
    tbl[15] = '{4'b0001, OP_MOV, 32'h0,         32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 4'b1001};
    tbl[16] = '{4'b0000, OP_BIC, 32'hFF,        32'h0F,        1'b1, 1'b1, 32'hF0,        1'b1, 4'b0010};
    tbl[17] = '{4'b0000, OP_MVN, 32'h0,         32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 4'b1000};
    tbl[18] = '{4'b0000, OP_SUB, 32'h0,         32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 4'b1001};
    tbl[19] = '{4'b0000, OP_ADD, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 32'h0,         1'b1, 4'b0110};

    rst_n = 1'b0; in_valid = 1'b0; op_mul = 1'b0; mul_acc = 1'b0; set_flags = 1'b0;
    sh_c = 1'b0; flags_ld = 1'b0; flags_d = 4'h0; out_ready = 1'b1; alu_op = 4'h0;
    src_a = '0; src_b = '0; src_c = '0; m_nzcv = 4'h0;

    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset alu_out", alu_out, 0);
    chk("reset res_we", res_we, 0);
    chk("reset nzcv", nzcv, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-derived vector table
    for (int i = 0; i < 20; i++) begin
      load_flags(tbl[i].pre);
      drive(tbl[i].op, tbl[i].a, tbl[i].b, 32'd0, 1'b0, 1'b0, tbl[i].s, tbl[i].shc, 1'b0, 4'h0);
      chk($sformatf("tbl%0d out_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d res_we", i), res_we, tbl[i].we);
      if (tbl[i].we) chk($sformatf("tbl%0d alu_out", i), alu_out, tbl[i].out);
      chk($sformatf("tbl%0d nzcv", i), nzcv, tbl[i].nzcv);
      m_nzcv = tbl[i].nzcv;
    end

    // Back-to-back ADC sees the carry written on the previous edge
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    drive(OP_ADC, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("b2b adc alu_out", alu_out, 32'd1);

    // Flag load beats the compare update on the same edge
    drive(OP_CMP, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
    chk("flags_ld priority nzcv", nzcv, 4'b0011);
    drive(OP_ADC, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("adc after flags_ld alu_out", alu_out, 32'd1);
    m_nzcv = 4'b0011;

    // Multiply with S: N/Z updated, C/V preserved; then MLA
    load_flags(4'b0011);
    run_mul(32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("mul ffff^2 value", alu_out, 32'hFFFE_0001);
    chk("mul ffff^2 nzcv", nzcv, 4'b1011);
    run_mul(32'd3, 32'd4, 32'd10, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("mla 3*4+10", alu_out, 32'd22);

    // Backpressure: result held, then drain and accept on one edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    alu_op = OP_ADD; src_a = 32'd5; src_b = 32'd6; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall alu_out held", alu_out, 32'd3);
      chk("stall out_valid held", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("drain in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain+accept alu_out", alu_out, 32'd11);
    chk("drain+accept out_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("drained out_valid", out_valid, 0);
    chk("drained alu_out", alu_out, 32'd0);

    // Asynchronous reset in the middle of a multiply
    load_flags(4'b1111);
    drive(4'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset nzcv", nzcv, 0);
    chk("async reset busy", busy, 0);
    chk("async reset out_valid", out_valid, 0);
    chk("async reset alu_out", alu_out, 0);
    #3;
    rst_n = 1'b1;
    m_nzcv = 4'h0;
    @(posedge clk); #1;
    chk("post reset in_ready", in_ready, 1);
    chk("post reset no stale out_valid", out_valid, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      logic ld; logic [3:0] fd;
      ld = ($urandom_range(0, 9) == 0);
      fd = 4'($urandom());
      if ($urandom_range(0, 11) == 0)
        run_mul($urandom(), $urandom(), $urandom(), 1'($urandom()), 1'($urandom()), ld, fd);
      else
        run_alu(4'($urandom()), rnd_opnd(), rnd_opnd(), 1'($urandom()), 1'($urandom()), ld, fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational ARM-style data-processing ALU.
- Same 16-opcode encoding (AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN).
- Adds a block-owned NZCV flag register, valid/ready handshakes on input and output, and an iterative shift-add MUL/MLA unit.
- Sits between operand fetch/shifter and writeback in the execute stage.

Parameters:
- WIDTH, 32: datapath width. Must be ≥ 4.
- MUL_EN, 1: 1 builds the multiplier. 0 treats op_mul as 0.
- CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept this cycle.
- alu_op  in  4  data-processing opcode.
- op_mul  in  1  multiply request; alu_op is ignored when set.
- mul_acc  in  1  MLA: add src_c to the product.
- set_flags  in  1  S bit.
- src_a  in  WIDTH  operand Rn / multiplicand.
- src_b  in  WIDTH  operand shifter output / multiplier.
- src_c  in  WIDTH  MLA accumulate operand.
- sh_c  in  1  shifter carry-out, used for logic ops.
- flags_ld  in  1  direct flag load (MSR).
- flags_d  in  4  value for the direct flag load.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- alu_out  out  WIDTH  result.
- res_we  out  1  result is to be written back (0 for TST/TEQ/CMP/CMN).
- nzcv  out  4  flag register: [3]=N [2]=Z [1]=C [0]=V.
- busy  out  1  a multiply is in progress.

Behaviour:
- Reset values: all outputs 0, nzcv=4'b0000, FSM in IDLE. Reset is asynchronous and takes effect anywhere, including mid-multiply. The partial product is discarded and no output is produced.
- Handshake rules:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A request is accepted on a rising edge where in_valid && in_ready.
  - out_valid stays high and alu_out/res_we stay stable until out_valid && out_ready. They are then cleared, unless a new result loads on the same edge.
- Arithmetic rules:
  - All arithmetic is done in WIDTH+1 bits. C is bit WIDTH of the sum.
  - SUB/CMP compute a + ~b + 1. RSB computes b + ~a + 1.
  - ADC computes a + b + C. SBC computes a + ~b + C. RSC computes b + ~a + C. C is the registered flag.
  - For subtractions, C = NOT borrow. This holds for b=0 too: SUB x,0 gives C=1.
  - V = (opA[W-1]==opB'[W-1]) && (res[W-1]!=opA[W-1]), where opB' is the inverted or non-inverted second adder input.
  - Logic ops (AND EOR TST TEQ ORR MOV BIC MVN): C=sh_c, V unchanged.
- ALU op timing (1-cycle latency):
  - On the accept edge: alu_out, res_we and out_valid are loaded.
  - The flag update happens on the same edge. It applies if set_flags or the op is a compare (TST TEQ CMP CMN always update).
  - A back-to-back ADC on the next edge sees the new C.
- FSM states:
  - IDLE: accept with op_mul=1 (and MUL_EN=1) goes to MUL.
    - Load acc = mul_acc ? src_c : 0, mcand = src_a, mplier = src_b, cnt = 0.
  - MUL: each edge, if mplier[0] then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
    - The edge where cnt reaches WIDTH writes the final acc to alu_out, sets out_valid and res_we=1, and returns to IDLE.
    - Multiply latency is exactly WIDTH cycles from accept. Result = low WIDTH bits of a*b(+c).
    - If set_flags was set at accept, N and Z are updated on the completion edge. C and V are preserved.
- Busy and stalls:
  - busy = (state==MUL). in_ready=0 while busy.
  - The multiply does not stall on out_ready. The output register is guaranteed empty or drained at accept, per the in_ready rule.
- Simultaneous events:
  - flags_ld on the same edge as an op flag update: flags_ld wins for all four bits.
  - flags_ld while busy: applied immediately. MUL completion then overwrites N and Z only.
- Width rule: no other state depends on WIDTH beyond the datapath and the counter.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_AND=4'h0 … OP_MVN=4'hF);
  - NZCV bit indices;
  - FSM state enum (IDLE, MUL);
  - function is_compare(op).
- One sub-module, alu_mul_iter: holds acc/mcand/mplier/cnt and signals done. The top holds the combinational ALU, the flag register and the handshake.

Test Plan:
- Overflow: ADD 0x7FFFFFFF + 0x00000001, set_flags=1 -> next cycle alu_out=0x80000000, nzcv=4'b1001, res_we=1.
- Compare: CMP 5,5 -> nzcv=4'b0110, res_we=0. Then SUB 7,0 with S -> alu_out=7, C=1. Then SBC 7,3 (C=1) -> 4. Then SBC 7,3 with C=0 -> 3.
- Multiply: MUL 0xFFFF × 0xFFFF, set_flags=1 -> out_valid rises exactly 32 cycles after accept, alu_out=0xFFFE0001, N=1, Z=0, C/V unchanged, busy high for 32 cycles, in_ready=0 throughout. MLA 3×4+10 -> 22.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, alu_out stable. Raise out_ready with in_valid=1 -> drain and accept on the same edge, new result visible next cycle.
- Reset mid-multiply: assert rst_n=0 at cycle 10 of a MUL, asynchronously between edges -> outputs and nzcv go 0 immediately. After release, in_ready=1 and no stale out_valid.
- Flag load priority: flags_ld=1 with flags_d=4'b0011 on the same edge as CMP 1,2 -> nzcv=4'b0011. The next ADC 0,0 -> alu_out=1.
